// File: rtl/vld_unit.sv
// Vector load: streams n words from memory into one VRF register, up to MAX_OUTST reads in flight.
// VRF write lands 1 cycle after each response; read request held stable under mem_rd_ready backpressure.
module vld_unit #(
  parameter int VLMAX      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int VREG_WIDTH = 5,
  parameter int CNT_WIDTH  = 6,
  parameter int MAX_OUTST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] ADDR_IN,
  input  logic [CNT_WIDTH-1:0]  N_DATA_IN,
  input  logic [VREG_WIDTH-1:0] VR_IN,
  output logic                  mem_rd_valid,
  input  logic                  mem_rd_ready,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  vrf_we,
  output logic [ADDR_WIDTH-1:0] vrf_waddr,
  output logic [DATA_WIDTH-1:0] vrf_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_WIDTH-1:0] VLMAX_C = CNT_WIDTH'(VLMAX);
  localparam logic [OW-1:0]        MAX_O   = OW'(MAX_OUTST);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] vbase_q, vbase_d;
  logic [CNT_WIDTH-1:0]  n_q, n_d;
  logic [CNT_WIDTH-1:0]  issued_q, issued_d;
  logic [CNT_WIDTH-1:0]  recv_q, recv_d;
  logic [OW-1:0]         outst_q, outst_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  issue_fire;
  logic                  rsp_acc;
  logic [CNT_WIDTH-1:0]  n_clamp;
  logic [ADDR_WIDTH-1:0] vbase_in;

  assign issue_fire = rd_vld_q && mem_rd_ready;
  // Responses with nothing outstanding belong to an aborted load and are dropped.
  assign rsp_acc    = mem_rsp_valid && (outst_q != '0);
  assign n_clamp    = (N_DATA_IN > VLMAX_C) ? VLMAX_C : N_DATA_IN;
  assign vbase_in   = ADDR_WIDTH'(VR_IN) * ADDR_WIDTH'(VLMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      vbase_q   <= '0;
      n_q       <= '0;
      issued_q  <= '0;
      recv_q    <= '0;
      outst_q   <= '0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      vbase_q   <= vbase_d;
      n_q       <= n_d;
      issued_q  <= issued_d;
      recv_q    <= recv_d;
      outst_q   <= outst_d;
      rd_vld_q  <= rd_vld_d;
      rd_addr_q <= rd_addr_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_RUN;
      S_RUN:   if (recv_q == n_q) state_d = S_DONE;
      S_DONE:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_DONE);
  end

  always_comb begin
    base_d    = base_q;
    vbase_d   = vbase_q;
    n_d       = n_q;
    issued_d  = issued_q + CNT_WIDTH'(issue_fire);
    recv_d    = recv_q + CNT_WIDTH'(rsp_acc);
    outst_d   = outst_q + OW'(issue_fire) - OW'(rsp_acc);
    rd_vld_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    we_d      = rsp_acc;
    waddr_d   = rsp_acc ? vbase_q + ADDR_WIDTH'(recv_q) : waddr_q;
    wdata_d   = rsp_acc ? mem_rsp_data : wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          base_d    = ADDR_IN;
          vbase_d   = vbase_in;
          n_d       = n_clamp;
          issued_d  = '0;
          recv_d    = '0;
          outst_d   = '0;
          rd_vld_d  = (n_clamp != '0);
          rd_addr_d = ADDR_IN;
        end
      end
      S_RUN: begin
        // Next request is judged on post-handshake counts, so a stalled request never drops.
        rd_vld_d = (issued_d < n_q) && (outst_d < MAX_O);
        if (rd_vld_d) rd_addr_d = base_q + ADDR_WIDTH'(issued_d);
      end
      default: ;
    endcase
  end

  assign mem_rd_valid = rd_vld_q;
  assign mem_rd_addr  = rd_addr_q;
  assign vrf_we       = we_q;
  assign vrf_waddr    = waddr_q;
  assign vrf_wdata    = wdata_q;

endmodule

// File: tb/tb_vld_unit.sv
// Scoreboard bench for vld_unit: memory model + VRF write monitor against a per-command expectation list.
module tb_vld_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] ADDR_IN = '0;
  logic [5:0]  N_DATA_IN = '0;
  logic [4:0]  VR_IN = '0;
  logic        mem_rd_valid;
  logic        mem_rd_ready = 1'b0;
  logic [31:0] mem_rd_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        vrf_we;
  logic [31:0] vrf_waddr;
  logic [31:0] vrf_wdata;
  logic        resp_valid;
  logic        resp_ready = 1'b0;

  vld_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .ADDR_IN(ADDR_IN), .N_DATA_IN(N_DATA_IN), .VR_IN(VR_IN),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .vrf_we(vrf_we), .vrf_waddr(vrf_waddr), .vrf_wdata(vrf_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          checks = 0;
  int          failures = 0;
  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  logic [31:0] pend[$];
  logic [31:0] stale[$];
  int          rsp_mode = 0;   // 0 always answer, 1 random, 2 withhold
  int          rdy_mode = 0;   // 0 always ready, 1 random
  int          spur_mode = 1;  // stray responses while nothing is in flight: 0 off, 1 random, 2 always
  int          rd_total = 0;
  int          wr_total = 0;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s: unexpected event, value %0h expected none", name, act);
  endtask

  // Memory model: answers reads in order, checks request address and stall stability.
  initial begin
    logic        prev_stall;
    logic [31:0] prev_addr;
    bit          go;
    prev_stall = 1'b0;
    prev_addr  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_rsp_valid = 1'b0;
        mem_rd_ready  = 1'b0;
        while (pend.size() > 0) stale.push_back(pend.pop_front());
        exp_rd.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("rd_hold_valid", {63'b0, mem_rd_valid}, 64'd1);
          check("rd_hold_addr", {32'b0, mem_rd_addr}, {32'b0, prev_addr});
        end
        go = (rsp_mode == 0) ? 1'b1 : (rsp_mode == 1) ? bit'($urandom_range(0, 1)) : 1'b0;
        if (pend.size() > 0 && go) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = memval(pend.pop_front());
        end else if (pend.size() == 0 &&
                     (spur_mode == 2 || (spur_mode == 1 && $urandom_range(0, 3) == 0))) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = (stale.size() > 0) ? memval(stale.pop_front()) : $urandom;
        end else begin
          mem_rsp_valid = 1'b0;
        end
        mem_rd_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (mem_rd_valid && mem_rd_ready) begin
          rd_total++;
          if (exp_rd.size() == 0) fail_now("unexpected_rd", {32'b0, mem_rd_addr});
          else check("rd_addr", {32'b0, mem_rd_addr}, {32'b0, exp_rd.pop_front()});
          pend.push_back(mem_rd_addr);
          check("outstanding_le_max", {63'b0, pend.size() <= 4}, 64'd1);
        end
        prev_stall = mem_rd_valid && !mem_rd_ready;
        prev_addr  = mem_rd_addr;
      end
    end
  end

  // VRF write monitor.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_wr.delete();
      end else if (vrf_we) begin
        wr_total++;
        if (exp_wr.size() == 0) begin
          fail_now("unexpected_vrf_we", {vrf_waddr, vrf_wdata});
        end else begin
          e = exp_wr.pop_front();
          check("vrf_waddr", {32'b0, vrf_waddr}, {32'b0, e.addr});
          check("vrf_wdata", {32'b0, vrf_wdata}, {32'b0, e.data});
        end
      end
    end
  end

  task automatic check_reset();
    check("rst_req_ready", {63'b0, req_ready}, 64'd1);
    check("rst_mem_rd_valid", {63'b0, mem_rd_valid}, 64'd0);
    check("rst_mem_rd_addr", {32'b0, mem_rd_addr}, 64'd0);
    check("rst_vrf_we", {63'b0, vrf_we}, 64'd0);
    check("rst_vrf_waddr", {32'b0, vrf_waddr}, 64'd0);
    check("rst_vrf_wdata", {32'b0, vrf_wdata}, 64'd0);
    check("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
  endtask

  // Called at posedge+2; returns at posedge+2 just after the accepting edge.
  task automatic issue_cmd(input logic [31:0] a, input logic [5:0] nin, input logic [4:0] vr);
    int          n;
    int          w;
    wr_t         e;
    logic [31:0] vb;
    n  = (nin > 6'd32) ? 32 : int'(nin);
    vb = 32'(vr) * 32'd32;
    for (int k = 0; k < n; k++) begin
      exp_rd.push_back(a + 32'(k));
      e.addr = vb + 32'(k);
      e.data = memval(a + 32'(k));
      exp_wr.push_back(e);
    end
    ADDR_IN   = a;
    N_DATA_IN = nin;
    VR_IN     = vr;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 100) begin
      @(posedge clk); #2;
      w++;
    end
    if (!req_ready) fail_now("req_ready_timeout", 64'd0);
    @(posedge clk); #2;
    req_valid = 1'b0;
  endtask

  task automatic finish_cmd(input int n, input int wr_start);
    int w;
    int d;
    w = 0;
    while (!resp_valid && w < 3000) begin
      @(posedge clk); #2;
      w++;
    end
    check("resp_valid_seen", {63'b0, resp_valid}, 64'd1);
    check("writes_before_resp", 64'(exp_wr.size()), 64'd0);
    check("reads_before_resp", 64'(exp_rd.size()), 64'd0);
    check("write_count", 64'(wr_total - wr_start), 64'(n));
    d = int'($urandom_range(0, 3));
    repeat (d) begin
      @(posedge clk); #2;
      check("resp_held", {63'b0, resp_valid}, 64'd1);
    end
    resp_ready = 1'b1;
    @(posedge clk); #2;
    resp_ready = 1'b0;
    check("resp_cleared", {63'b0, resp_valid}, 64'd0);
    check("req_ready_back", {63'b0, req_ready}, 64'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          s;
    int          s2;
    int          r;
    int          w;
    int          n;
    logic [31:0] a;
    logic [5:0]  nin;
    logic [4:0]  vr;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    check_reset();

    // Basic 4-word load, 1-cycle memory.
    rdy_mode = 0; rsp_mode = 0;
    s = wr_total;
    issue_cmd(32'h100, 6'd4, 5'd2);
    finish_cmd(4, s);

    // Zero-length load: completion two cycles after accept.
    s = wr_total;
    issue_cmd(32'h40, 6'd0, 5'd1);
    check("n0_resp_not_yet", {63'b0, resp_valid}, 64'd0);
    @(posedge clk); #2;
    check("n0_resp_2cyc", {63'b0, resp_valid}, 64'd1);
    finish_cmd(0, s);

    // Withheld responses: read issue stops at the in-flight limit.
    rsp_mode = 2;
    s = wr_total;
    r = rd_total;
    issue_cmd(32'h2000, 6'd8, 5'd3);
    repeat (12) @(posedge clk);
    #2;
    check("stall_reads_issued", 64'(rd_total - r), 64'd4);
    check("stall_no_writes", 64'(wr_total - s), 64'd0);
    check("stall_rd_valid_low", {63'b0, mem_rd_valid}, 64'd0);
    rsp_mode = 0;
    finish_cmd(8, s);

    // Toggling ready and random response timing.
    rdy_mode = 1; rsp_mode = 1;
    s = wr_total;
    issue_cmd(32'h3000, 6'd3, 5'd4);
    finish_cmd(3, s);
    s = wr_total;
    issue_cmd(32'h3100, 6'd8, 5'd6);
    finish_cmd(8, s);

    // Clamp to VLMAX, top register, address wrap.
    rdy_mode = 0; rsp_mode = 0;
    s = wr_total;
    issue_cmd(32'hFFFF_FFFE, 6'd40, 5'd31);
    finish_cmd(32, s);

    // Reset in the middle of a load; stale responses must not write.
    s = wr_total;
    issue_cmd(32'h500, 6'd6, 5'd5);
    w = 0;
    while ((wr_total - s) < 2 && w < 200) begin
      @(posedge clk); #2;
      w++;
    end
    check("midload_two_writes", 64'(wr_total - s), 64'd2);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    check_reset();
    spur_mode = 2;
    s2 = wr_total;
    repeat (8) @(posedge clk);
    #2;
    check("no_wr_after_rst", 64'(wr_total - s2), 64'd0);
    check("idle_after_rst", {63'b0, req_ready}, 64'd1);
    spur_mode = 1;

    // Randomized commands.
    repeat (25) begin
      rdy_mode = int'($urandom_range(0, 1));
      rsp_mode = int'($urandom_range(0, 1));
      a   = $urandom;
      nin = 6'($urandom_range(0, 63));
      vr  = 5'($urandom_range(0, 31));
      n   = (nin > 6'd32) ? 32 : int'(nin);
      s   = wr_total;
      issue_cmd(a, nin, vr);
      finish_cmd(n, s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
